// File: rtl/pll_lock_rst_ctrl_if.sv
// Lock status in, reset/status outputs out: the signal bundle around the PLL lock/reset controller.
interface pll_lock_rst_ctrl_if;
  logic       locked;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic [7:0] lock_lost_cnt;
  logic       timeout_err;

  modport master (
    input  locked,
    output pll_rst, sys_rst, ready, lock_lost_cnt, timeout_err
  );

  modport slave (
    output locked,
    input  pll_rst, sys_rst, ready, lock_lost_cnt, timeout_err
  );
endinterface

// File: rtl/pll_lock_rst_ctrl.sv
// PLL bring-up sequencer: pulses the PLL reset, qualifies lock, then releases the downstream
// reset. Any loss of lock after qualification restarts the whole sequence.
module pll_lock_rst_ctrl #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 36000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int HOLD_CYCLES    = 64
) (
  input  logic                refclk,
  input  logic                rst,
  pll_lock_rst_ctrl_if.master bus
);
  localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CD  = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
  localparam int MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W   = (MAX_ALL > 1) ? $clog2(MAX_ALL) : 1;

  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_HOLD      = 3'd3,
    S_RUN       = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sync_q, sync_d;
  logic             lock_s;
  logic             pll_rst_q, pll_rst_d;
  logic             sys_rst_q, sys_rst_d;
  logic             ready_q, ready_d;
  logic [7:0]       lost_q, lost_d;
  logic             timeout_err_q, timeout_err_d;

  // locked is asynchronous to refclk; only the second stage is trusted.
  assign sync_d = {sync_q[0], bus.locked};
  assign lock_s = sync_q[1];

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    lost_d        = lost_q;
    timeout_err_d = timeout_err_q;

    unique case (state_q)
      S_PLL_RST: begin
        if (cnt_q == PLL_RST_LAST) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d       = S_PLL_RST;
          cnt_d         = '0;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STABLE: begin
        if (!lock_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HOLD, S_RUN: begin
        // Loss of lock wins over HOLD expiry; RUN keeps the counter parked so it never wraps.
        if (!lock_s) begin
          state_d = S_PLL_RST;
          cnt_d   = '0;
          if (lost_q != 8'hFF) begin
            lost_d = lost_q + 8'd1;
          end
        end else if (state_q == S_HOLD) begin
          if (cnt_q == HOLD_LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = S_PLL_RST;
        cnt_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state so they change on the same edge as the state.
    pll_rst_d = (state_d == S_PLL_RST);
    ready_d   = (state_d == S_RUN);
    sys_rst_d = !ready_d;
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q       <= S_PLL_RST;
      cnt_q         <= '0;
      sync_q        <= 2'b00;
      pll_rst_q     <= 1'b1;
      sys_rst_q     <= 1'b1;
      ready_q       <= 1'b0;
      lost_q        <= 8'd0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sync_q        <= sync_d;
      pll_rst_q     <= pll_rst_d;
      sys_rst_q     <= sys_rst_d;
      ready_q       <= ready_d;
      lost_q        <= lost_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.pll_rst       = pll_rst_q;
  assign bus.sys_rst       = sys_rst_q;
  assign bus.ready         = ready_q;
  assign bus.lock_lost_cnt = lost_q;
  assign bus.timeout_err   = timeout_err_q;
endmodule

// File: tb/tb_pll_lock_rst_ctrl.sv
`timescale 1ns/1ps
// Bench for pll_lock_rst_ctrl: directed scenarios plus random lock/reset traffic, all compared
// against a lifecycle model that tracks phase durations from timestamps and a lock-history queue.
module tb_pll_lock_rst_ctrl;
  localparam int PRC = 4;
  localparam int LTO = 20;
  localparam int STC = 8;
  localparam int HDC = 4;
  localparam logic [11:0] RST_VEC = 12'b110_0000_0000_0;

  localparam int PH_PLL  = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_STAB = 2;
  localparam int PH_HOLD = 3;
  localparam int PH_RUN  = 4;

  logic refclk = 1'b0;
  logic rst    = 1'b1;

  pll_lock_rst_ctrl_if ifc ();

  pll_lock_rst_ctrl #(
    .PLL_RST_CYCLES(PRC),
    .LOCK_TIMEOUT  (LTO),
    .STABLE_CYCLES (STC),
    .HOLD_CYCLES   (HDC)
  ) dut (
    .refclk(refclk),
    .rst   (rst),
    .bus   (ifc)
  );

  always #5 refclk = ~refclk;

  int n_tests = 0;
  int n_fail  = 0;

  int cyc       = 0;
  int m_phase   = PH_PLL;
  int m_entered = 0;
  int m_lost    = 0;
  bit m_terr    = 1'b0;
  bit m_hist[$] = '{1'b0, 1'b0};

  logic [11:0] exp_vec;
  logic [11:0] dut_vec;
  assign exp_vec = {m_phase == PH_PLL, m_phase != PH_RUN, m_phase == PH_RUN, 8'(m_lost), m_terr};
  assign dut_vec = {ifc.pll_rst, ifc.sys_rst, ifc.ready, ifc.lock_lost_cnt, ifc.timeout_err};

  function void enter(input int ph);
    m_phase   = ph;
    m_entered = cyc;
  endfunction

  // The decision at each edge uses the lock value sampled two edges earlier.
  always @(posedge refclk) begin : ref_model
    bit ls;
    int dwell;
    cyc = cyc + 1;
    if (rst) begin
      enter(PH_PLL);
      m_lost = 0;
      m_terr = 1'b0;
      m_hist = '{1'b0, 1'b0};
    end else begin
      ls = m_hist.pop_front();
      m_hist.push_back(ifc.locked);
      dwell = cyc - m_entered;
      case (m_phase)
        PH_PLL:  if (dwell == PRC) enter(PH_WAIT);
        PH_WAIT: begin
          if (ls) enter(PH_STAB);
          else if (dwell == LTO) begin
            enter(PH_PLL);
            m_terr = 1'b1;
          end
        end
        PH_STAB: begin
          if (!ls) enter(PH_WAIT);
          else if (dwell == STC) enter(PH_HOLD);
        end
        default: begin
          if (!ls) begin
            enter(PH_PLL);
            m_lost = (m_lost < 255) ? m_lost + 1 : 255;
          end else if (m_phase == PH_HOLD && dwell == HDC) begin
            enter(PH_RUN);
          end
        end
      endcase
    end
  end

  // Returns at the negedge where rst has just been released (cycle 0 of the new sequence).
  task automatic apply_reset(input bit lk, input int n);
    @(negedge refclk);
    rst        = 1'b1;
    ifc.locked = lk;
    repeat (n) @(negedge refclk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge refclk);
    rst        = 1'b1;
    ifc.locked = 1'($urandom_range(0, 1));
    repeat (2) @(negedge refclk);
    n_tests++;
    if (dut_vec !== RST_VEC) begin
      n_fail++;
      $display("FAIL reset_state got=%b exp=%b", dut_vec, RST_VEC);
    end
    n_tests++;
    if (dut_vec !== exp_vec) begin
      n_fail++;
      $display("FAIL reset_model got=%b exp=%b", dut_vec, exp_vec);
    end
  endtask

  task automatic test_lock_ok();
    int pll_hi = 0;
    int rise   = -1;
    apply_reset(1'b1, 2);
    for (int i = 0; i <= 24; i++) begin
      if (i > 0) @(negedge refclk);
      n_tests++;
      if (dut_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL lock_ok_model i=%0d got=%b exp=%b", i, dut_vec, exp_vec);
      end
      if (ifc.pll_rst === 1'b1) pll_hi++;
      if (rise < 0 && ifc.ready === 1'b1) rise = i;
    end
    n_tests++;
    if (pll_hi != PRC) begin
      n_fail++;
      $display("FAIL lock_ok_pll_cycles got=%0d exp=%0d", pll_hi, PRC);
    end
    n_tests++;
    if (rise != PRC + 1 + STC + HDC) begin
      n_fail++;
      $display("FAIL lock_ok_ready_rise got=%0d exp=%0d", rise, PRC + 1 + STC + HDC);
    end
    n_tests++;
    if (ifc.lock_lost_cnt !== 8'd0 || ifc.timeout_err !== 1'b0 || ifc.sys_rst !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_ok_status got=%0d/%b/%b exp=0/0/0", ifc.lock_lost_cnt, ifc.timeout_err, ifc.sys_rst);
    end
  endtask

  task automatic test_no_lock();
    apply_reset(1'b0, 2);
    for (int i = 0; i <= 60; i++) begin
      if (i > 0) @(negedge refclk);
      n_tests++;
      if (dut_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL no_lock_model i=%0d got=%b exp=%b", i, dut_vec, exp_vec);
      end
      n_tests++;
      if (ifc.pll_rst !== ((i % (PRC + LTO)) < PRC) || ifc.ready !== 1'b0 ||
          ifc.timeout_err !== (i >= PRC + LTO)) begin
        n_fail++;
        $display("FAIL no_lock_pattern i=%0d got=pll%b rdy%b terr%b", i, ifc.pll_rst, ifc.ready, ifc.timeout_err);
      end
    end
  endtask

  task automatic test_stable_glitch();
    int rise = -1;
    apply_reset(1'b1, 2);
    for (int i = 0; i <= 32; i++) begin
      if (i > 0) @(negedge refclk);
      n_tests++;
      if (dut_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL glitch_model i=%0d got=%b exp=%b", i, dut_vec, exp_vec);
      end
      if (i >= PRC) begin
        n_tests++;
        if (ifc.pll_rst !== 1'b0 || ifc.lock_lost_cnt !== 8'd0) begin
          n_fail++;
          $display("FAIL glitch_no_pll_rst i=%0d got=pll%b lost%0d exp=pll0 lost0", i, ifc.pll_rst, ifc.lock_lost_cnt);
        end
      end
      if (rise < 0 && ifc.ready === 1'b1) rise = i;
      if (i == 8)  ifc.locked = 1'b0;
      if (i == 10) ifc.locked = 1'b1;
    end
    // STABLE is abandoned at edge 11 and re-entered at edge 13, so RUN arrives 8 cycles later.
    n_tests++;
    if (rise != 25) begin
      n_fail++;
      $display("FAIL glitch_ready_rise got=%0d exp=25", rise);
    end
  endtask

  task automatic test_run_drop();
    logic [7:0] base;
    int pll_hi = 0;
    base = ifc.lock_lost_cnt;
    ifc.locked = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge refclk);
      n_tests++;
      if (dut_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL run_drop_model i=%0d got=%b exp=%b", i, dut_vec, exp_vec);
      end
      if (i == 2) begin
        n_tests++;
        if (ifc.sys_rst !== 1'b0) begin
          n_fail++;
          $display("FAIL run_drop_early got=%b exp=0", ifc.sys_rst);
        end
      end
      if (i == 3) begin
        n_tests++;
        if (ifc.sys_rst !== 1'b1 || ifc.ready !== 1'b0 || ifc.lock_lost_cnt !== base + 8'd1) begin
          n_fail++;
          $display("FAIL run_drop_latency got=sys%b rdy%b lost%0d exp=sys1 rdy0 lost%0d",
                   ifc.sys_rst, ifc.ready, ifc.lock_lost_cnt, base + 8'd1);
        end
      end
      if (ifc.pll_rst === 1'b1) pll_hi++;
      if (i == 1) ifc.locked = 1'b1;
    end
    n_tests++;
    if (pll_hi != PRC || ifc.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL run_drop_requal got=pll%0d rdy%b exp=pll%0d rdy1", pll_hi, ifc.ready, PRC);
    end
    for (int d = 0; d < 300; d++) begin
      ifc.locked = 1'b0;
      @(negedge refclk);
      ifc.locked = 1'b1;
      repeat (3) @(negedge refclk);
      for (int k = 0; k < 60 && ifc.ready !== 1'b1; k++) begin
        @(negedge refclk);
        n_tests++;
        if (dut_vec !== exp_vec) begin
          n_fail++;
          $display("FAIL drops_model d=%0d got=%b exp=%b", d, dut_vec, exp_vec);
        end
      end
      n_tests++;
      if (ifc.ready !== 1'b1) begin
        n_fail++;
        $display("FAIL drops_requal_timeout d=%0d got=rdy%b exp=rdy1", d, ifc.ready);
      end
    end
    n_tests++;
    if (ifc.lock_lost_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL drops_saturate got=%0d exp=255", ifc.lock_lost_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int rise = -1;
    apply_reset(1'b0, 2);
    repeat (26) @(negedge refclk);
    ifc.locked = 1'b1;
    for (int k = 0; k < 60 && ifc.ready !== 1'b1; k++) @(negedge refclk);
    for (int d = 0; d < 5; d++) begin
      ifc.locked = 1'b0;
      @(negedge refclk);
      ifc.locked = 1'b1;
      repeat (3) @(negedge refclk);
      for (int k = 0; k < 60 && ifc.ready !== 1'b1; k++) @(negedge refclk);
    end
    n_tests++;
    if (ifc.ready !== 1'b1 || ifc.lock_lost_cnt !== 8'd5 || ifc.timeout_err !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_setup got=rdy%b lost%0d terr%b exp=rdy1 lost5 terr1",
               ifc.ready, ifc.lock_lost_cnt, ifc.timeout_err);
    end
    rst = 1'b1;
    @(negedge refclk);
    rst = 1'b0;
    n_tests++;
    if (dut_vec !== RST_VEC) begin
      n_fail++;
      $display("FAIL reset_mid_state got=%b exp=%b", dut_vec, RST_VEC);
    end
    for (int i = 0; i <= 20; i++) begin
      if (i > 0) @(negedge refclk);
      n_tests++;
      if (dut_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL reset_mid_model i=%0d got=%b exp=%b", i, dut_vec, exp_vec);
      end
      if (rise < 0 && ifc.ready === 1'b1) rise = i;
    end
    n_tests++;
    if (rise != PRC + 1 + STC + HDC) begin
      n_fail++;
      $display("FAIL reset_mid_restart got=%0d exp=%0d", rise, PRC + 1 + STC + HDC);
    end
  endtask

  task automatic test_random();
    int run_left = 0;
    apply_reset(1'b1, 1);
    for (int i = 0; i < 3000; i++) begin
      @(negedge refclk);
      n_tests++;
      if (dut_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL random_model i=%0d got=%b exp=%b", i, dut_vec, exp_vec);
      end
      rst = ($urandom_range(0, 299) == 0);
      if (run_left == 0) begin
        ifc.locked = ~ifc.locked;
        run_left   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : $urandom_range(10, 60);
      end
      run_left--;
    end
    rst = 1'b0;
  endtask

  initial begin
    ifc.locked = 1'b0;
    rst        = 1'b1;
    test_reset();
    test_lock_ok();
    test_no_lock();
    test_stable_glitch();
    test_run_drop();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
